// File: rtl/prime_alive_generator.sv
// Two-channel PRIME/ALIVE stimulus generator driven by a host command port.
// Define PRIME_ALIVE_GEN_FAULT_INJECT_EN to build the fault-injection opcodes (0x4-0x6).
module prime_alive_generator #(
    parameter int unsigned HALF_PERIOD = 50,
    parameter int unsigned ARM_EDGES   = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    input  logic [31:0] CMD_DATA,
    output logic        CMD_READY,
    output logic [1:0]  PRIME,
    output logic [1:0]  ALIVE,
    output logic [3:0]  GEN_STATE,
    output logic        CMD_ERROR
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StArming = 2'b01,
        StActive = 2'b10,
        StFault  = 2'b11
    } gen_state_e;

    localparam logic [3:0]  OpStart      = 4'h1;
    localparam logic [3:0]  OpStop       = 4'h2;
    localparam logic [3:0]  OpSetHalf    = 4'h3;
    localparam logic [3:0]  OpFaultStuck = 4'h4;
    localparam logic [3:0]  OpFaultDrop  = 4'h5;
    localparam logic [3:0]  OpClearFault = 4'h6;
    localparam logic [15:0] HalfInit     = 16'(HALF_PERIOD);
    localparam logic [7:0]  ArmLast      = 8'(ARM_EDGES - 1);

    logic        ready_q, pend_q, error_q, error_d;
    logic [3:0]  op_q;
    logic        ch_q;
    logic [15:0] arg_q;
    logic        accept;

    gen_state_e  state_q  [2];
    gen_state_e  state_d  [2];
    logic [15:0] cnt_q    [2];
    logic [15:0] cnt_d    [2];
    logic [15:0] half_q   [2];
    logic [15:0] half_d   [2];
    logic [15:0] shadow_q [2];
    logic [15:0] shadow_d [2];
    logic [7:0]  arm_q    [2];
    logic [7:0]  arm_d    [2];
    logic [1:0]  alive_q, alive_d, prime_q, prime_d;
    logic [1:0]  hit, run, tgl;
`ifdef PRIME_ALIVE_GEN_FAULT_INJECT_EN
    logic [1:0]  stuck_q, stuck_d;
`endif

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{CMD_DATA[27:25], CMD_DATA[23:16]};

    assign accept = CMD_VALID & ready_q;

    // Accepted command is held one cycle and executed on the following edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
            error_q <= 1'b0;
            op_q    <= 4'h0;
            ch_q    <= 1'b0;
            arg_q   <= 16'h0;
            alive_q <= 2'b00;
            prime_q <= 2'b00;
`ifdef PRIME_ALIVE_GEN_FAULT_INJECT_EN
            stuck_q <= 2'b00;
`endif
            for (int i = 0; i < 2; i++) begin
                state_q[i]  <= StIdle;
                cnt_q[i]    <= 16'h0;
                arm_q[i]    <= 8'h0;
                half_q[i]   <= HalfInit;
                shadow_q[i] <= HalfInit;
            end
        end else begin
            ready_q <= ~accept;
            pend_q  <= accept;
            if (accept) begin
                op_q  <= CMD_DATA[31:28];
                ch_q  <= CMD_DATA[24];
                arg_q <= CMD_DATA[15:0];
            end
            error_q <= error_d;
            alive_q <= alive_d;
            prime_q <= prime_d;
`ifdef PRIME_ALIVE_GEN_FAULT_INJECT_EN
            stuck_q <= stuck_d;
`endif
            for (int i = 0; i < 2; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                arm_q[i]    <= arm_d[i];
                half_q[i]   <= half_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    always_comb begin
        error_d = error_q;
        alive_d = alive_q;
        prime_d = prime_q;
        hit     = 2'b00;
        run     = 2'b00;
        tgl     = 2'b00;
`ifdef PRIME_ALIVE_GEN_FAULT_INJECT_EN
        stuck_d = stuck_q;
`endif
        if (pend_q && (op_q > OpClearFault)) begin
            error_d = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            arm_d[i]    = arm_q[i];
            half_d[i]   = half_q[i];
            shadow_d[i] = shadow_q[i];
            hit[i] = pend_q && (ch_q == 1'(i));
            run[i] = (state_q[i] == StArming) || (state_q[i] == StActive);
`ifdef PRIME_ALIVE_GEN_FAULT_INJECT_EN
            if ((state_q[i] == StFault) && !stuck_q[i]) begin
                run[i] = 1'b1;
            end
`endif
            tgl[i] = run[i] && (cnt_q[i] == half_q[i] - 16'd1);

            // Half-period retune only takes effect on a toggle edge.
            if (run[i]) begin
                if (tgl[i]) begin
                    cnt_d[i]   = 16'h0;
                    alive_d[i] = ~alive_q[i];
                    half_d[i]  = shadow_q[i];
                    if (arm_q[i] != 8'hFF) begin
                        arm_d[i] = arm_q[i] + 8'd1;
                    end
                    if ((state_q[i] == StArming) && (arm_q[i] == ArmLast)) begin
                        state_d[i] = StActive;
                        prime_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end

            // An executing command overrides the free-running update above.
            if (hit[i]) begin
                case (op_q)
                    OpStart: begin
                        if (state_q[i] == StIdle) begin
                            state_d[i] = StArming;
                            cnt_d[i]   = 16'h0;
                            arm_d[i]   = 8'h0;
                            half_d[i]  = shadow_q[i];
                            alive_d[i] = 1'b0;
                            prime_d[i] = 1'b0;
                        end
                    end
                    OpStop: begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 16'h0;
                        arm_d[i]   = 8'h0;
                        alive_d[i] = 1'b0;
                        prime_d[i] = 1'b0;
`ifdef PRIME_ALIVE_GEN_FAULT_INJECT_EN
                        stuck_d[i] = 1'b0;
`endif
                    end
                    OpSetHalf: begin
                        shadow_d[i] = (arg_q == 16'h0) ? 16'd1 : arg_q;
                    end
`ifdef PRIME_ALIVE_GEN_FAULT_INJECT_EN
                    OpFaultStuck: begin
                        if (state_q[i] == StActive) begin
                            state_d[i] = StFault;
                            stuck_d[i] = 1'b1;
                            cnt_d[i]   = 16'h0;
                            alive_d[i] = arg_q[0];
                        end
                    end
                    OpFaultDrop: begin
                        if (state_q[i] == StActive) begin
                            state_d[i] = StFault;
                            stuck_d[i] = 1'b0;
                            prime_d[i] = 1'b0;
                        end
                    end
                    OpClearFault: begin
                        if (state_q[i] == StFault) begin
                            state_d[i] = StArming;
                            stuck_d[i] = 1'b0;
                            cnt_d[i]   = 16'h0;
                            arm_d[i]   = 8'h0;
                            half_d[i]  = shadow_q[i];
                            alive_d[i] = 1'b0;
                            prime_d[i] = 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign CMD_READY = ready_q;
    assign CMD_ERROR = error_q;
    assign PRIME     = prime_q;
    assign ALIVE     = alive_q;
    assign GEN_STATE = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_prime_alive_generator.sv
// Scoreboard bench for prime_alive_generator: expected output snapshots keyed by edge number.
// Expectations for fault opcodes follow PRIME_ALIVE_GEN_FAULT_INJECT_EN.
module tb_prime_alive_generator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic [31:0] CMD_DATA = 32'h0;
    logic        CMD_READY;
    logic [1:0]  PRIME;
    logic [1:0]  ALIVE;
    logic [3:0]  GEN_STATE;
    logic        CMD_ERROR;

    prime_alive_generator #(
        .HALF_PERIOD(50),
        .ARM_EDGES  (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_DATA  (CMD_DATA),
        .CMD_READY (CMD_READY),
        .PRIME     (PRIME),
        .ALIVE     (ALIVE),
        .GEN_STATE (GEN_STATE),
        .CMD_ERROR (CMD_ERROR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Snapshot layout: PRIME[9:8] ALIVE[7:6] GEN_STATE[5:2] CMD_ERROR[1] CMD_READY[0]
    wire [9:0] obs = {PRIME, ALIVE, GEN_STATE, CMD_ERROR, CMD_READY};

    localparam logic [9:0] MP0 = 10'b01_00_0000_0_0;
    localparam logic [9:0] MP1 = 10'b10_00_0000_0_0;
    localparam logic [9:0] MA0 = 10'b00_01_0000_0_0;
    localparam logic [9:0] MA1 = 10'b00_10_0000_0_0;
    localparam logic [9:0] MG0 = 10'b00_00_0011_0_0;
    localparam logic [9:0] MG1 = 10'b00_00_1100_0_0;
    localparam logic [9:0] ME  = 10'b00_00_0000_1_0;
    localparam logic [9:0] MR  = 10'b00_00_0000_0_1;
    localparam logic [9:0] MC0 = MP0 | MA0 | MG0;
    localparam logic [9:0] MC1 = MP1 | MA1 | MG1;

    typedef struct {
        int         at;
        logic [9:0] mask;
        logic [9:0] val;
        string      name;
    } exp_t;

    typedef struct {
        int          at;
        logic [31:0] data;
    } cmd_t;

    exp_t sb[$];
    cmd_t cq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [9:0] v(logic [1:0] p, logic [1:0] a, logic [3:0] g, logic er,
                                     logic r);
        return {p, a, g, er, r};
    endfunction

    function automatic logic [31:0] cmd(logic [3:0] op, logic ch, logic [15:0] arg);
        return {op, 3'b000, ch, 8'h00, arg};
    endfunction

    task automatic exp_at(int at, string name, logic [9:0] mask, logic [9:0] val);
        exp_t e;
        int   i;
        e.at = at; e.name = name; e.mask = mask; e.val = val;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    task automatic send_at(int at, logic [31:0] data);
        cmd_t c;
        c.at = at; c.data = data;
        cq.push_back(c);
    endtask

    // Advance to the next falling edge and present any command due on the coming rising edge.
    task automatic step();
        cmd_t c;
        @(negedge CLK);
        if (cq.size() != 0 && cq[0].at == cyc + 1) begin
            c = cq.pop_front();
            CMD_VALID = 1'b1;
            CMD_DATA  = c.data;
        end else begin
            CMD_VALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        exp_at(3, "reset_state", 10'h3FF, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(4, "ready_after_release", 10'h3FF, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b1));
        while (sb.size() != 0 || cq.size() != 0) begin
            step();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc || (obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, e.at,
                             obs & e.mask, e.val & e.mask);
                end
            end
            if (cyc == 3) RESET = 1'b0;
        end
    endtask

    task automatic test_start_default();
        exp_t e;
        send_at(10, cmd(4'h1, 1'b0, 16'h0));
        exp_at(10, "start_ready_low", MR | MG0, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(11, "start_arming", 10'h3FF, v(2'b00, 2'b00, 4'b0001, 1'b0, 1'b1));
        exp_at(60, "alive_before_first", MA0, 10'h0);
        exp_at(61, "alive_first_rise", MC1 | MA0 | MP0, v(2'b00, 2'b01, 4'h0, 1'b0, 1'b0));
        exp_at(111, "alive_first_fall", MA0, 10'h0);
        exp_at(410, "prime_before_arm", MP0 | MG0, v(2'b00, 2'b00, 4'b0001, 1'b0, 1'b0));
        exp_at(411, "prime_rise", MC0 | MC1, v(2'b01, 2'b00, 4'b0010, 1'b0, 1'b0));
        while (sb.size() != 0 || cq.size() != 0) begin
            step();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc || (obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, e.at,
                             obs & e.mask, e.val & e.mask);
                end
            end
        end
    endtask

    task automatic test_set_half();
        exp_t e;
        send_at(420, cmd(4'h3, 1'b0, 16'd20));
        send_at(510, cmd(4'h3, 1'b0, 16'd0));
        exp_at(440, "half_no_early_copy", MA0, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(460, "half_old_completes", MA0, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(461, "half_old_toggle", MA0, v(2'b00, 2'b01, 4'h0, 1'b0, 1'b0));
        exp_at(480, "half20_hold", MA0, v(2'b00, 2'b01, 4'h0, 1'b0, 1'b0));
        exp_at(481, "half20_toggle", MA0, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(500, "half20_hold2", MA0, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(501, "half20_toggle2", MA0, v(2'b00, 2'b01, 4'h0, 1'b0, 1'b0));
        exp_at(520, "half0_pending", MA0, v(2'b00, 2'b01, 4'h0, 1'b0, 1'b0));
        exp_at(521, "half0_copy", MA0, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(522, "half1_a", MA0, v(2'b00, 2'b01, 4'h0, 1'b0, 1'b0));
        exp_at(523, "half1_b", MA0, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(524, "half1_c", MC0, v(2'b01, 2'b01, 4'b0010, 1'b0, 1'b0));
        while (sb.size() != 0 || cq.size() != 0) begin
            step();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc || (obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, e.at,
                             obs & e.mask, e.val & e.mask);
                end
            end
        end
    endtask

    task automatic test_fault();
        exp_t e;
        send_at(530, cmd(4'h1, 1'b1, 16'h0));
        send_at(940, cmd(4'h4, 1'b1, 16'h1));
        send_at(999, cmd(4'h6, 1'b1, 16'h0));
        send_at(1410, cmd(4'h5, 1'b1, 16'h0));
        send_at(1460, cmd(4'h2, 1'b1, 16'h0));
        exp_at(531, "ch1_arming", MC1, v(2'b00, 2'b00, 4'b0100, 1'b0, 1'b0));
        exp_at(931, "ch1_active", MC1, v(2'b10, 2'b00, 4'b1000, 1'b0, 1'b0));
`ifdef PRIME_ALIVE_GEN_FAULT_INJECT_EN
        exp_at(941, "stuck_enter", MC1 | ME, v(2'b10, 2'b10, 4'b1100, 1'b0, 1'b0));
        exp_at(981, "stuck_hold", MC1, v(2'b10, 2'b10, 4'b1100, 1'b0, 1'b0));
        exp_at(998, "stuck_hold2", MC1, v(2'b10, 2'b10, 4'b1100, 1'b0, 1'b0));
        exp_at(1000, "clear_rearm", MC1, v(2'b00, 2'b00, 4'b0100, 1'b0, 1'b0));
        exp_at(1049, "clear_alive_low", MA1, 10'h0);
        exp_at(1050, "clear_alive_rise", MA1, v(2'b00, 2'b10, 4'h0, 1'b0, 1'b0));
        exp_at(1399, "clear_prime_low", MP1 | MG1, v(2'b00, 2'b00, 4'b0100, 1'b0, 1'b0));
        exp_at(1400, "clear_prime_rise", MC1, v(2'b10, 2'b00, 4'b1000, 1'b0, 1'b0));
        exp_at(1411, "drop_enter", MC1, v(2'b00, 2'b00, 4'b1100, 1'b0, 1'b0));
        exp_at(1450, "drop_alive_runs", MC1, v(2'b00, 2'b10, 4'b1100, 1'b0, 1'b0));
`else
        exp_at(941, "stuck_ignored", MC1 | ME, v(2'b10, 2'b00, 4'b1000, 1'b0, 1'b0));
        exp_at(981, "stuck_ignored_tgl", MC1, v(2'b10, 2'b10, 4'b1000, 1'b0, 1'b0));
        exp_at(1000, "clear_ignored", MC1 | ME, v(2'b10, 2'b10, 4'b1000, 1'b0, 1'b0));
        exp_at(1031, "clear_ignored_tgl", MC1, v(2'b10, 2'b00, 4'b1000, 1'b0, 1'b0));
        exp_at(1411, "drop_ignored", MC1 | ME, v(2'b10, 2'b10, 4'b1000, 1'b0, 1'b0));
        exp_at(1450, "drop_ignored_tgl", MC1, v(2'b10, 2'b00, 4'b1000, 1'b0, 1'b0));
`endif
        exp_at(1461, "ch1_stop", MC1 | ME, v(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
        while (sb.size() != 0 || cq.size() != 0) begin
            step();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc || (obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, e.at,
                             obs & e.mask, e.val & e.mask);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // Valid held for four cycles; only the 1st and 3rd words may be taken.
        send_at(1471, cmd(4'h2, 1'b0, 16'h0));
        send_at(1472, cmd(4'hF, 1'b0, 16'h0));
        send_at(1473, cmd(4'h0, 1'b1, 16'h0));
        send_at(1474, cmd(4'hF, 1'b1, 16'h0));
        send_at(1480, cmd(4'hF, 1'b0, 16'h0));
        exp_at(1470, "b2b_ready_1", MR, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b1));
        exp_at(1471, "b2b_ready_0", MR, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(1472, "b2b_ready_1b", MR | MC0, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b1));
        exp_at(1473, "b2b_ready_0b", MR, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b0));
        exp_at(1474, "b2b_ready_end", MR, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b1));
        exp_at(1476, "b2b_no_error", MR | ME, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b1));
        exp_at(1480, "bad_op_pending", ME, 10'h0);
        exp_at(1481, "bad_op_error", ME, v(2'b00, 2'b00, 4'h0, 1'b1, 1'b0));
        exp_at(1500, "error_sticky", ME | MG0 | MG1, v(2'b00, 2'b00, 4'h0, 1'b1, 1'b0));
        while (sb.size() != 0 || cq.size() != 0) begin
            step();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc || (obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, e.at,
                             obs & e.mask, e.val & e.mask);
                end
            end
        end
    endtask

    task automatic test_stop_on_arm();
        exp_t e;
        send_at(1510, cmd(4'h3, 1'b0, 16'd4));
        send_at(1520, cmd(4'h1, 1'b0, 16'h0));
        send_at(1552, cmd(4'h2, 1'b0, 16'h0));
        exp_at(1521, "soa_arming", MC0, v(2'b00, 2'b00, 4'b0001, 1'b0, 1'b0));
        exp_at(1525, "soa_first_tgl", MA0, v(2'b00, 2'b01, 4'h0, 1'b0, 1'b0));
        exp_at(1552, "soa_seventh", MC0, v(2'b00, 2'b01, 4'b0001, 1'b0, 1'b0));
        exp_at(1553, "soa_stop_wins", MC0, v(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0));
        exp_at(1560, "soa_stays_idle", MC0 | ME, v(2'b00, 2'b00, 4'b0000, 1'b1, 1'b0));
        while (sb.size() != 0 || cq.size() != 0) begin
            step();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc || (obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, e.at,
                             obs & e.mask, e.val & e.mask);
                end
            end
        end
    endtask

    task automatic test_reset_mid_arming();
        exp_t e;
        send_at(1570, cmd(4'h1, 1'b0, 16'h0));
        send_at(1573, cmd(4'h3, 1'b0, 16'd7));
        send_at(1590, cmd(4'h1, 1'b0, 16'h0));
        exp_at(1575, "rma_arming", MG0 | ME, v(2'b00, 2'b00, 4'b0001, 1'b1, 1'b0));
        exp_at(1576, "rma_reset", 10'h3FF, 10'h0);
        exp_at(1577, "rma_reset_hold", 10'h3FF, 10'h0);
        exp_at(1578, "rma_release", 10'h3FF, v(2'b00, 2'b00, 4'h0, 1'b0, 1'b1));
        exp_at(1591, "rma_restart", MC0, v(2'b00, 2'b00, 4'b0001, 1'b0, 1'b0));
        exp_at(1598, "rma_no_short_half", MA0, 10'h0);
        exp_at(1640, "rma_half50_low", MA0, 10'h0);
        exp_at(1641, "rma_half50_rise", MC0, v(2'b00, 2'b01, 4'b0001, 1'b0, 1'b0));
        while (sb.size() != 0 || cq.size() != 0) begin
            step();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc || (obs & e.mask) !== (e.val & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, e.at,
                             obs & e.mask, e.val & e.mask);
                end
            end
            if (cyc == 1575) RESET = 1'b1;
            if (cyc == 1577) RESET = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: edge %0d reached, expected completion before 20000", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_start_default();
        test_set_half();
        test_fault();
        test_back_to_back();
        test_stop_on_arm();
        test_reset_mid_arming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prime_alive_generator.md
# prime_alive_generator

Two-channel PRIME/ALIVE stimulus generator: the transmitting end of the PRIME/ALIVE health interface. Drives a PRIME level and an ALIVE square wave per channel. A host command port arms, stops, retunes and fault-injects each channel. Used on the test equipment to exercise the prime/alive monitor at 10 MHz.

## Interface
- `HALF_PERIOD`, 50: reset ALIVE half-period in CLK cycles. 50 = 5 us edge spacing at 10 MHz.
- `ARM_EDGES`, 8: ALIVE toggles in ARMING before PRIME asserts.
- `CLK` in 1: system clock, 10 MHz.
- `RESET` in 1: reset. Synchronous, active-high.
- `CMD_VALID` in 1: command present.
- `CMD_DATA` in 32: command word.
  - [31:28] opcode.
  - [24] channel.
  - [15:0] argument.
- `CMD_READY` out 1: command accepted when VALID & READY.
- `PRIME` out 2: PRIME level per channel (bit n = channel n).
- `ALIVE` out 2: ALIVE square wave per channel.
- `GEN_STATE` out 4: state per channel. [1:0] = channel 0, [3:2] = channel 1.
- `CMD_ERROR` out 1: sticky illegal-command flag.

## Operation
Opcodes:
- 0x0 NOP.
- 0x1 START.
- 0x2 STOP.
- 0x3 SET_HALF: argument = new half-period. Argument 0 is treated as 1.
- 0x4 FAULT_STUCK: argument[0] = stuck ALIVE level.
- 0x5 FAULT_DROP_PRIME.
- 0x6 CLEAR_FAULT.
- Any other opcode: no effect on channels, sets CMD_ERROR.

Per-channel FSM (GEN_STATE encoding):
- IDLE (00): PRIME=0, ALIVE=0, counters held at 0.
  - START → ARMING.
- ARMING (01): ALIVE toggles, PRIME=0.
  - On the ARM_EDGES-th toggle → ACTIVE.
  - START is ignored.
- ACTIVE (10): ALIVE toggles, PRIME=1.
  - START is ignored.
  - FAULT_* → FAULT.
- FAULT (11), stuck variant: ALIVE is forced to the argument level. PRIME holds its value at fault entry.
- FAULT (11), drop-PRIME variant: ALIVE keeps toggling, PRIME=0.
- In FAULT:
  - CLEAR_FAULT → ARMING, with the toggle and arm counters cleared and ALIVE=0.
  - START is ignored.
- STOP: any state → IDLE.
- FAULT_* outside ACTIVE, or CLEAR_FAULT outside FAULT: no effect, no error.

ALIVE generation:
- A 16-bit cycle counter counts 0..half−1.
- When the counter reaches half−1, ALIVE toggles and the counter resets to 0.
- The arm counter is 8 bits and saturates.

SET_HALF:
- Writes a per-channel shadow register.
- The shadow is copied to the active half-period only at a toggle, or on entry to ARMING. Periods never glitch mid-half-cycle.

## Timing
- Command handshake:
  - A command is accepted at edge N.
  - CMD_READY=0 during cycle N+1.
  - The command executes at edge N+1.
  - CMD_READY=1 again from cycle N+2.
  - Maximum command rate is one per 2 cycles.
- START accepted at edge N:
  - GEN_STATE=01 after edge N+1.
  - First ALIVE rise after edge N+1+H, where H = active half-period.
  - PRIME rises at edge N+1+ARM_EDGES·H, coincident with the ARM_EDGES-th toggle.
- All outputs are registered. No combinational path from CMD_* to outputs except none; CMD_READY is also registered.
- Simultaneous arm-complete and command execution on the same edge: the command wins.
  - Example: STOP on the ARM_EDGES-th toggle edge → IDLE, PRIME stays 0.
- RESET asserted at any edge, regardless of operation in progress:
  - PRIME=0, ALIVE=0, GEN_STATE=0.
  - CMD_ERROR=0, CMD_READY=0, pending command discarded.
  - Shadow and active half-period = HALF_PERIOD.
- Release: CMD_READY=1 in the first cycle after the first edge with RESET low.

## Configuration
- Macro `PRIME_ALIVE_GEN_FAULT_INJECT_EN`.
- Defined: opcodes 0x4–0x6 behave as above.
- Undefined:
  - 0x4–0x6 are accepted and treated as NOP. They do not set CMD_ERROR.
  - State 11 is unreachable.
  - The fault logic is not synthesized.

## Test plan
- Reset, START ch0 accepted at edge 10, default parameters → GEN_STATE[1:0]=01 at edge 11, ALIVE[0] rises at edge 61, PRIME[0] rises at edge 411, ALIVE[1]/PRIME[1] stay 0.
- In ACTIVE, SET_HALF ch0 = 20 mid half-cycle → current half completes at 50 cycles, next halves are 20 cycles. SET_HALF 0 → 1-cycle halves.
- Back-to-back CMD_VALID for 4 cycles → exactly 2 commands accepted, CMD_READY pattern 1,0,1,0. Opcode 0xF → CMD_ERROR=1 until RESET.
- ACTIVE ch1, FAULT_STUCK arg 1 → ALIVE[1]=1 constant, PRIME[1]=1, GEN_STATE[3:2]=11. CLEAR_FAULT → 01, ALIVE[1]=0, PRIME re-rises after 400 cycles. With the macro undefined → outputs unchanged, no error.
- STOP ch0 on the same edge as the 8th toggle → IDLE, PRIME[0] never asserts.
- RESET mid-ARMING with SET_HALF pending → all outputs 0, half-period back to 50 on the next START.
